// File: rtl/bitheap_bist.sv
// bitheap_bist: LFSR stimulus generator and golden-sum checker
// for the 12x12 multiplier bit-heap compressor.
`timescale 1ns/1ps
module bitheap_bist #(
    parameter int          N_VEC = 20000,
    parameter int          LAT   = 1,
    parameter logic [31:0] SEED  = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [1:0]  in_col0,
    output logic        in_col1,
    output logic [2:0]  in_col2,
    output logic [1:0]  in_col3,
    output logic [3:0]  in_col4,
    output logic [2:0]  in_col5,
    output logic [4:0]  in_col6,
    output logic [3:0]  in_col7,
    output logic [5:0]  in_col8,
    output logic [4:0]  in_col9,
    output logic [6:0]  in_col10,
    output logic [5:0]  in_col11,
    output logic [6:0]  in_col12,
    output logic [5:0]  in_col13,
    output logic [4:0]  in_col14,
    output logic [4:0]  in_col15,
    output logic [3:0]  in_col16,
    output logic [3:0]  in_col17,
    output logic [2:0]  in_col18,
    output logic [2:0]  in_col19,
    output logic [1:0]  in_col20,
    output logic [1:0]  in_col21,
    output logic        in_col22,
    output logic        in_col23,
    input  logic [24:0] comp_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [15:0] first_err_idx
);

    // Column heights, one nibble per column, column 0 in the low nibble.
    localparam logic [95:0] HGT = 96'h1122_3344_5567_6756_4534_2312;
    localparam logic [31:0] S0  = SEED;
    localparam logic [31:0] S1  = SEED ^ 32'h5A5A_5A5A;
    localparam logic [31:0] S2  = SEED ^ 32'hA5A5_A5A5;
    localparam logic [15:0] NV  = 16'(N_VEC);
    localparam logic [3:0]  LT  = 4'(LAT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [31:0] step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    function automatic logic [4:0] col_of(input int j);
        int         acc;
        logic [4:0] c;
        acc = 0;
        c   = '0;
        for (int k = 0; k < 24; k++) begin
            acc += int'(HGT[4*k +: 4]);
            if (acc <= j) c = c + 5'd1;
        end
        return c;
    endfunction

    state_t        state, state_n;
    logic          go, issue, miss;
    logic [31:0]   l0, l1, l2;
    logic [90:0]   heap;
    logic          heap_v;
    logic [15:0]   vec_idx, heap_idx;
    logic [3:0]    dcnt;
    logic [24:0]   gold;
    logic [LAT-1:0] pv;
    logic [23:0]   pref [LAT];
    logic [15:0]   pidx [LAT];
    logic          unused_ok;

    assign unused_ok = ^{comp_out[24], gold[24]};

    always_comb begin
        state_n = state;
        go      = 1'b0;
        issue   = 1'b0;
        unique case (state)
            IDLE, DONE: if (start) begin
                state_n = RUN;
                go      = 1'b1;
            end
            RUN: if (vec_idx == NV) state_n = DRAIN;
                 else issue = 1'b1;
            DRAIN: if (dcnt == LT) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        gold = '0;
        for (int j = 0; j < 91; j++)
            gold = gold + (heap[j] ? (25'd1 << col_of(j)) : 25'd0);
    end

    assign miss = pv[LAT-1] && (comp_out[23:0] != pref[LAT-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            l0            <= S0;
            l1            <= S1;
            l2            <= S2;
            heap          <= '0;
            heap_v        <= 1'b0;
            vec_idx       <= '0;
            heap_idx      <= '0;
            dcnt          <= '0;
            pv            <= '0;
            err_cnt       <= '0;
            first_err_idx <= 16'hFFFF;
        end else begin
            heap   <= '0;
            heap_v <= 1'b0;
            dcnt   <= (state == DRAIN) ? dcnt + 4'd1 : 4'd0;
            // A fresh run issues vector 0 straight from the seeds.
            if (go) begin
                heap     <= {S2[26:0], S1, S0};
                heap_v   <= 1'b1;
                heap_idx <= '0;
                vec_idx  <= 16'd1;
                l0       <= step(S0);
                l1       <= step(S1);
                l2       <= step(S2);
            end else if (issue) begin
                heap     <= {l2[26:0], l1, l0};
                heap_v   <= 1'b1;
                heap_idx <= vec_idx;
                vec_idx  <= vec_idx + 16'd1;
                l0       <= step(l0);
                l1       <= step(l1);
                l2       <= step(l2);
            end
            pv[0]   <= heap_v;
            pref[0] <= gold[23:0];
            pidx[0] <= heap_idx;
            for (int s = 1; s < LAT; s++) begin
                pv[s]   <= pv[s-1];
                pref[s] <= pref[s-1];
                pidx[s] <= pidx[s-1];
            end
            if (go) begin
                err_cnt       <= '0;
                first_err_idx <= 16'hFFFF;
            end else if (miss) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (first_err_idx == 16'hFFFF) first_err_idx <= pidx[LAT-1];
            end
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == 16'd0);

    assign in_col0  = heap[1:0];
    assign in_col1  = heap[2];
    assign in_col2  = heap[5:3];
    assign in_col3  = heap[7:6];
    assign in_col4  = heap[11:8];
    assign in_col5  = heap[14:12];
    assign in_col6  = heap[19:15];
    assign in_col7  = heap[23:20];
    assign in_col8  = heap[29:24];
    assign in_col9  = heap[34:30];
    assign in_col10 = heap[41:35];
    assign in_col11 = heap[47:42];
    assign in_col12 = heap[54:48];
    assign in_col13 = heap[60:55];
    assign in_col14 = heap[65:61];
    assign in_col15 = heap[70:66];
    assign in_col16 = heap[74:71];
    assign in_col17 = heap[78:75];
    assign in_col18 = heap[81:79];
    assign in_col19 = heap[84:82];
    assign in_col20 = heap[86:85];
    assign in_col21 = heap[88:87];
    assign in_col22 = heap[89];
    assign in_col23 = heap[90];

endmodule

// File: tb/tb_bitheap_bist.sv
// tb_bitheap_bist: three BIST instances (16/1, 100/3, 20000/1) fed by a
// compressor model and checked against an LFSR + weighted-popcount reference.
`timescale 1ns/1ps
module tb_bitheap_bist;

    localparam logic [31:0] SEED = 32'hACE1_2024;
    localparam int BIG = 32'h7FFF_FFFF;
    localparam int NV [3] = '{16, 100, 20000};
    localparam int LV [3] = '{1, 3, 1};
    localparam int NR [3] = '{3, 3, 1};

    typedef struct {
        int depth;
        int fidx;
        bit tie0;
        int rst_at;
    } scen_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input int g, input string nm,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL g%0d %s: got %0h want %0h", g, nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    // Weighted sum: popcount of each column times 2^column.
    function automatic logic [24:0] heap_sum(input logic [90:0] f);
        int hts [24] = '{2,1,3,2,4,3,5,4,6,5,7,6,7,6,5,5,4,4,3,3,2,2,1,1};
        int p = 0;
        logic [24:0] s = '0;
        for (int k = 0; k < 24; k++) begin
            int pc = 0;
            for (int b = 0; b < hts[k]; b++) begin
                pc += int'(f[p]);
                p++;
            end
            s += 25'(pc) << k;
        end
        return s;
    endfunction

    // Run plans: ideal/fault/tied-0 for g0; aborted/ideal/short model for g1.
    function automatic scen_t scen(int g, int r);
        scen_t s;
        s = '{1, -1, 1'b0, -1};
        if (g == 0 && r == 1) s.fidx = 3;
        if (g == 0 && r == 2) s.tie0 = 1'b1;
        if (g == 1) s.depth = (r == 2) ? 2 : 3;
        if (g == 1 && r == 0) begin
            s.tie0   = 1'b1;
            s.rst_at = 50;
        end
        return s;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int N = NV[g];
        localparam int L = LV[g];

        logic rst, start, busy, done, pass;
        logic [24:0] comp;
        logic [15:0] ec, fe;
        logic [1:0] c0;  logic c1;       logic [2:0] c2;  logic [1:0] c3;
        logic [3:0] c4;  logic [2:0] c5; logic [4:0] c6;  logic [3:0] c7;
        logic [5:0] c8;  logic [4:0] c9; logic [6:0] c10; logic [5:0] c11;
        logic [6:0] c12; logic [5:0] c13;
        logic [4:0] c14, c15;
        logic [3:0] c16, c17;
        logic [2:0] c18, c19;
        logic [1:0] c20, c21;
        logic c22, c23;
        logic [90:0] flat;

        assign flat = {c23, c22, c21, c20, c19, c18, c17, c16, c15, c14, c13, c12,
                       c11, c10, c9, c8, c7, c6, c5, c4, c3, c2, c1, c0};

        bitheap_bist #(.N_VEC(N), .LAT(L), .SEED(SEED)) dut (
            .clk(clk), .rst(rst), .start(start),
            .in_col0(c0),   .in_col1(c1),   .in_col2(c2),   .in_col3(c3),
            .in_col4(c4),   .in_col5(c5),   .in_col6(c6),   .in_col7(c7),
            .in_col8(c8),   .in_col9(c9),   .in_col10(c10), .in_col11(c11),
            .in_col12(c12), .in_col13(c13), .in_col14(c14), .in_col15(c15),
            .in_col16(c16), .in_col17(c17), .in_col18(c18), .in_col19(c19),
            .in_col20(c20), .in_col21(c21), .in_col22(c22), .in_col23(c23),
            .comp_out(comp), .busy(busy), .done(done), .pass(pass),
            .err_cnt(ec), .first_err_idx(fe)
        );

        int cyc = BIG;
        int run = 0;
        int depth = 1;
        int fidx = -1;
        bit tie0 = 1'b0;
        int nfin = 0;
        bit fin = 1'b0;
        logic [24:0] cp [8] = '{default: '0};
        logic [15:0] r_err [3] = '{default: '0};
        logic [15:0] r_fei [3] = '{default: '0};
        logic r_pass [3] = '{default: 1'b0};
        logic [90:0] v0 = '0;
        logic [90:0] v1 = '0;

        // Compressor model; cyc is the index of the vector now on in_col.
        always @(posedge clk) begin
            cp[0] <= heap_sum(flat) ^ ((cyc == fidx) ? 25'h20 : 25'h0);
            for (int s = 1; s < 8; s++) cp[s] <= cp[s-1];
            if (rst) cyc <= BIG;
            else if (start) cyc <= 0;
            else if (cyc < BIG) cyc <= cyc + 1;
        end
        assign comp = tie0 ? 25'h0 : cp[depth-1];

        logic [31:0] m0, m1, m2;
        logic [24:0] gq [$];
        logic [24:0] gv;
        logic [90:0] ef;
        int sb_err, sb_first;

        always @(negedge clk) begin
            if (cyc < N + L + 4) begin
                if (cyc == 0) begin
                    m0 = SEED;
                    m1 = SEED ^ 32'h5A5A_5A5A;
                    m2 = SEED ^ 32'hA5A5_A5A5;
                    gq.delete();
                    sb_err = 0;
                    sb_first = -1;
                end
                ef = '0;
                if (cyc < N) begin
                    ef = {m2[26:0], m1, m0};
                    gq.push_back(heap_sum(ef));
                    m0 = lfsr(m0);
                    m1 = lfsr(m1);
                    m2 = lfsr(m2);
                end
                if (run == 0 && cyc == 0) v0 = flat;
                if (run == 0 && cyc == 1) v1 = flat;
                chk(g, "in_col", flat, ef);
                chk(g, "busy", busy, cyc < N + L + 1);
                chk(g, "done", done, cyc >= N + L + 1);
                if (cyc >= L && cyc < N + L) begin
                    gv = gq.pop_front();
                    if (comp[23:0] != gv[23:0]) begin
                        sb_err++;
                        if (sb_first < 0) sb_first = cyc - L;
                    end
                end
                if (cyc == N + L + 1) begin
                    chk(g, "err_cnt", ec, (sb_err > 65535) ? 16'hFFFF : 16'(sb_err));
                    chk(g, "first_err", fe, (sb_first < 0) ? 16'hFFFF : 16'(sb_first));
                    chk(g, "pass", pass, sb_err == 0);
                    r_err[run]  = ec;
                    r_fei[run]  = fe;
                    r_pass[run] = pass;
                    nfin++;
                end
            end
        end

        initial begin
            scen_t sc;
            int k;
            int want;
            rst = 1'b1;
            start = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk(g, "reset_values", {flat, busy, done, pass, ec, fe},
                {91'b0, 3'b0, 16'h0, 16'hFFFF});
            rst = 1'b0;
            for (int r = 0; r < NR[g]; r++) begin
                sc = scen(g, r);
                run = r;
                depth = sc.depth;
                fidx = sc.fidx;
                tie0 = sc.tie0;
                want = nfin + 1;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                if (sc.rst_at > 0) begin
                    repeat (sc.rst_at) @(posedge clk);
                    #1;
                    chk(g, "err_mid", ec, 16'd47);
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    chk(g, "mid_reset_values", {flat, busy, done, pass, ec, fe},
                        {91'b0, 3'b0, 16'h0, 16'hFFFF});
                end else begin
                    k = 0;
                    while (nfin < want && k < N + L + 20) begin
                        @(posedge clk);
                        k++;
                    end
                    chk(g, "run_end", nfin >= want, 1'b1);
                    repeat (3) @(posedge clk);
                    #1;
                end
            end
            fin = 1'b1;
        end
    end

    initial begin
        int k = 0;
        while (!(gi[0].fin && gi[1].fin && gi[2].fin) && k < 60000) begin
            @(posedge clk);
            k++;
        end
        chk(-1, "all_fin", {gi[0].fin, gi[1].fin, gi[2].fin}, 3'b111);
        chk(0, "v0_col0", gi[0].v0[1:0], 2'b00);
        chk(0, "v0_l0", gi[0].v0[31:0], 32'hACE1_2024);
        chk(0, "v1_l0", gi[0].v1[31:0], 32'h59C2_4048);
        chk(0, "ideal_pass", gi[0].r_pass[0], 1'b1);
        chk(0, "ideal_first", gi[0].r_fei[0], 16'hFFFF);
        chk(0, "fault_err", gi[0].r_err[1], 16'd1);
        chk(0, "fault_first", gi[0].r_fei[1], 16'd3);
        chk(0, "fault_pass", gi[0].r_pass[1], 1'b0);
        chk(0, "tie0_err", gi[0].r_err[2], 16'd16);
        chk(0, "tie0_first", gi[0].r_fei[2], 16'd0);
        chk(1, "after_rst_pass", gi[1].r_pass[1], 1'b1);
        chk(1, "after_rst_err", gi[1].r_err[1], 16'd0);
        chk(1, "lat2_ge90", gi[1].r_err[2] >= 16'd90, 1'b1);
        chk(2, "long_pass", gi[2].r_pass[0], 1'b1);
        chk(2, "long_first", gi[2].r_fei[0], 16'hFFFF);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
